// File: rtl/sd_pkg.sv
// Shared definitions for the time-shared "1011" detector scheduler.
//
// Contents:
//   det_state_t  - 2-bit detector context saved per channel
//                  (S0 = no prefix, S1 = "1", S2 = "10", S3 = "101")
//   NCH_DEF      - default number of serial input channels
//   CNT_W_DEF    - default width of each per-channel match counter
package sd_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sd_1011_step.sv
// Single shared "1011" detector step. It is purely combinational: it takes
// one channel's saved context and the bit just consumed, and produces the
// context to write back plus the match flag. Matching is overlapping, so
// after a hit the trailing "1" is kept as a fresh prefix.
//
// Ports:
//   state      - current saved context of the granted channel
//   data       - serial bit being consumed
//   next_state - context to store back for that channel
//   hit        - this bit completed "1011"
module sd_1011_step
    import sd_pkg::*;
(
    input  det_state_t state,
    input  logic       data,
    output det_state_t next_state,
    output logic       hit
);

    // Next-state table of the detector. A hit can only come from S3 with a 1,
    // and the detector then falls back to S1 because that "1" can start the
    // next overlapping match.
    always_comb begin
        next_state = S0;
        hit        = 1'b0;
        unique case (state)
            S0: next_state = data ? S1 : S0;
            S1: next_state = data ? S1 : S2;
            S2: next_state = data ? S3 : S0;
            S3: begin
                next_state = data ? S1 : S2;
                hit        = data;
            end
            default: next_state = S0;
        endcase
    end

endmodule

// File: rtl/sd_1011_rr_sched.sv
// Round-robin scheduler that time-shares one "1011" detector step among NCH
// serial bit streams. Each channel keeps its own saved detector context and
// a saturating match counter. One channel is granted per cycle; its context
// is stepped through the shared datapath and written back, and a tagged
// detect result appears registered one cycle later.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   ch_valid  - per-channel "bit present" flags
//   ch_bit    - per-channel serial data bits
//   ch_ready  - one-hot grant; a bit is consumed on ch_valid & ch_ready
//   clr_ch    - per-channel clear of context and counter (wins over a bit)
//   det_valid - a bit was consumed on the previous edge
//   det_ch    - channel of that bit (held when nothing is consumed)
//   det_hit   - that bit completed "1011"
//   hit_cnt   - flattened counters, channel i at [i*CNT_W +: CNT_W]
module sd_1011_rr_sched
    import sd_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [NCH-1:0]         ch_bit,
    output logic [NCH-1:0]         ch_ready,
    input  logic [NCH-1:0]         clr_ch,
    output logic                   det_valid,
    output logic [$clog2(NCH)-1:0] det_ch,
    output logic                   det_hit,
    output logic [NCH*CNT_W-1:0]   hit_cnt
);

    localparam int PW = $clog2(NCH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    grant_idx;
    logic             grant;
    int               search_idx;
    det_state_t       ctx [NCH];
    logic [CNT_W-1:0] cnt [NCH];
    det_state_t       cur_state;
    det_state_t       nxt_state;
    logic             step_hit;

    // Round-robin arbiter: walk the channels starting at rr_ptr, wrapping
    // past NCH-1 back to 0, and grant the first one that has a bit and is not
    // being cleared this cycle. Clearing masks the channel so its bit is left
    // unconsumed.
    always_comb begin
        ch_ready   = '0;
        grant      = 1'b0;
        grant_idx  = '0;
        search_idx = 0;
        for (int k = 0; k < NCH; k++) begin
            search_idx = (int'(rr_ptr) + k) % NCH;
            if (!grant && ch_valid[search_idx] && !clr_ch[search_idx]) begin
                grant     = 1'b1;
                grant_idx = PW'(search_idx);
            end
        end
        if (grant) begin
            ch_ready[grant_idx] = 1'b1;
        end
    end

    // The shared datapath only ever sees the granted channel's context.
    assign cur_state = ctx[grant_idx];

    sd_1011_step u_step (
        .state      (cur_state),
        .data       (ch_bit[grant_idx]),
        .next_state (nxt_state),
        .hit        (step_hit)
    );

    // Context, counter and pointer update. Only the granted channel's context
    // moves, so a stalled channel resumes exactly where it left off. A clear
    // can never coincide with a grant on the same channel because the arbiter
    // masks it. The counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < NCH; i++) begin
                ctx[i] <= S0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr_ch[i]) begin
                    ctx[i] <= S0;
                    cnt[i] <= '0;
                end else if (grant && (grant_idx == PW'(i))) begin
                    ctx[i] <= nxt_state;
                    if (step_hit && (cnt[i] != CNT_MAX)) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
            if (grant) begin
                rr_ptr <= (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
            end
        end
    end

    // Registered detect report. det_ch keeps the last granted channel when
    // nothing is consumed; det_valid and det_hit pulse for a single cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            det_valid <= 1'b0;
            det_hit   <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= grant;
            det_hit   <= grant && step_hit;
            if (grant) begin
                det_ch <= grant_idx;
            end
        end
    end

    // Flatten the counter array onto the output bus.
    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        assign hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_sd_1011_rr_sched.sv
// Self-checking bench for sd_1011_rr_sched. A default instance (NCH=4,
// CNT_W=8) covers arbitration, isolation, clear and random traffic; a second
// instance with CNT_W=2 covers counter saturation and mid-stream reset.
// The reference model tracks each channel's last four consumed bits and
// flags a match whenever they read 1011.
module tb_sd_1011_rr_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ch_valid, ch_bit, clr_ch, ch_ready;
    logic       det_valid, det_hit;
    logic [1:0] det_ch;
    logic [31:0] hit_cnt;

    logic       reset2;
    logic [3:0] ch_valid2, ch_bit2, clr_ch2, ch_ready2;
    logic       det_valid2, det_hit2;
    logic [1:0] det_ch2;
    logic [7:0] hit_cnt2;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         mptr;
    logic [3:0] mhist [4];
    int         exp_cnt [4];
    logic [3:0] exp_ready, seen_ready;
    logic       exp_dv, exp_dh;
    logic [1:0] exp_dch;
    logic [3:0] mhist2;
    int         exp_cnt2;
    logic       exp_dh2;

    always #5 clk = ~clk;

    sd_1011_rr_sched #(.NCH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_bit(ch_bit),
        .ch_ready(ch_ready), .clr_ch(clr_ch), .det_valid(det_valid),
        .det_ch(det_ch), .det_hit(det_hit), .hit_cnt(hit_cnt)
    );

    sd_1011_rr_sched #(.NCH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .ch_valid(ch_valid2), .ch_bit(ch_bit2),
        .ch_ready(ch_ready2), .clr_ch(clr_ch2), .det_valid(det_valid2),
        .det_ch(det_ch2), .det_hit(det_hit2), .hit_cnt(hit_cnt2)
    );

    // Reset the main instance and its model.
    task automatic doReset();
        reset = 1'b1; ch_valid = '0; ch_bit = '0; clr_ch = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        mptr = 0; exp_dv = 0; exp_dh = 0; exp_dch = 0;
        for (int i = 0; i < 4; i++) begin mhist[i] = '0; exp_cnt[i] = 0; end
    endtask

    // Drive one cycle on the main instance and advance the model; leaves the
    // expected grant/detect values in exp_* and the observed grant in seen_ready.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        int g;
        ch_valid = v; ch_bit = b; clr_ch = c;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (mptr + k) % 4;
            if (g < 0 && v[idx] && !c[idx]) g = idx;
        end
        exp_ready  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        seen_ready = ch_ready;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (c[i]) begin mhist[i] = '0; exp_cnt[i] = 0; end
        exp_dv = 1'b0; exp_dh = 1'b0;
        if (g >= 0) begin
            mhist[g] = {mhist[g][2:0], b[g]};
            exp_dv   = 1'b1;
            exp_dch  = 2'(g);
            exp_dh   = (mhist[g] == 4'b1011);
            if (exp_dh && exp_cnt[g] < 255) exp_cnt[g]++;
            mptr = (g + 1) % 4;
        end
        #1;
    endtask

    // Drive one cycle on the CNT_W=2 instance (channel 0 only) and its model.
    task automatic applyStimulus2(input logic v, input logic b, input logic r);
        reset2 = r; ch_valid2 = {3'b000, v}; ch_bit2 = {3'b000, b}; clr_ch2 = '0;
        @(posedge clk);
        exp_dh2 = 1'b0;
        if (r) begin
            mhist2 = '0; exp_cnt2 = 0;
        end else if (v) begin
            mhist2  = {mhist2[2:0], b};
            exp_dh2 = (mhist2 == 4'b1011);
            if (exp_dh2 && exp_cnt2 < 3) exp_cnt2++;
        end
        #1;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (det_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dv: got %0b want 0", det_valid); end
        total++; if (det_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_dh: got %0b want 0", det_hit); end
        total++; if (det_ch !== 2'd0) begin bad++; $display("[TB] FAIL reset_dch: got %0d want 0", det_ch); end
        total++; if (hit_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0h want 0", hit_cnt); end
        ch_valid = 4'b1111; #1;
        total++; if (ch_ready !== 4'b0001) begin bad++; $display("[TB] FAIL reset_prio: got %b want 0001", ch_ready); end
        ch_valid = '0;
    endtask

    // ch0 alone streams 1,0,1,1,0,1,1.
    task automatic test_single();
        logic [6:0] seq;
        seq = 7'b1011011;
        doReset();
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(4'b0001, {3'b000, seq[i]}, 4'b0000);
            total++; if (seen_ready !== 4'b0001) begin bad++; $display("[TB] FAIL single_ready: got %b want 0001", seen_ready); end
            total++; if (det_hit !== exp_dh) begin bad++; $display("[TB] FAIL single_hit: got %0b want %0b", det_hit, exp_dh); end
        end
        total++; if (hit_cnt[7:0] !== 8'd2) begin bad++; $display("[TB] FAIL single_cnt: got %0d want 2", hit_cnt[7:0]); end
    endtask

    // ch0 (1,0,1,1) and ch1 (1,1,1,1) continuously valid.
    task automatic test_back_to_back();
        logic [3:0] s0, s1;
        int i0, i1, hits;
        s0 = 4'b1011; s1 = 4'b1111; i0 = 0; i1 = 0; hits = 0;
        doReset();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b0011, {2'b00, s1[3-i1], s0[3-i0]}, 4'b0000);
            total++; if (seen_ready !== ((c % 2 == 0) ? 4'b0001 : 4'b0010)) begin bad++; $display("[TB] FAIL b2b_grant: got %b at cycle %0d", seen_ready, c); end
            total++; if (det_hit !== exp_dh || det_ch !== exp_dch) begin bad++; $display("[TB] FAIL b2b_det: got hit=%0b ch=%0d want hit=%0b ch=%0d", det_hit, det_ch, exp_dh, exp_dch); end
            if (det_hit) begin
                hits++;
                total++; if (c != 6) begin bad++; $display("[TB] FAIL b2b_hit_time: got cycle %0d want 6", c); end
            end
            if (seen_ready[0]) i0++; else if (seen_ready[1]) i1++;
            if (i0 > 3) i0 = 3;
            if (i1 > 3) i1 = 3;
        end
        total++; if (hits != 1) begin bad++; $display("[TB] FAIL b2b_hits: got %0d want 1", hits); end
        total++; if (hit_cnt[15:8] !== 8'd0) begin bad++; $display("[TB] FAIL b2b_cnt1: got %0d want 0", hit_cnt[15:8]); end
    endtask

    // ch2 sends 1,0,1 interleaved with ch3 sending 0,1,1, then ch2 sends 1.
    task automatic test_isolation();
        logic [2:0] s2, s3;
        s2 = 3'b101; s3 = 3'b011;
        doReset();
        for (int i = 2; i >= 0; i--) begin
            applyStimulus(4'b0100, {1'b0, s2[i], 2'b00}, 4'b0000);
            total++; if (det_hit !== 1'b0 || det_ch !== 2'd2) begin bad++; $display("[TB] FAIL iso_ch2: got hit=%0b ch=%0d want 0/2", det_hit, det_ch); end
            applyStimulus(4'b1000, {s3[i], 3'b000}, 4'b0000);
            total++; if (det_hit !== 1'b0 || det_ch !== 2'd3) begin bad++; $display("[TB] FAIL iso_ch3: got hit=%0b ch=%0d want 0/3", det_hit, det_ch); end
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        total++; if (det_valid !== 1'b0 || det_ch !== 2'd3) begin bad++; $display("[TB] FAIL iso_idle: got dv=%0b ch=%0d want 0/3", det_valid, det_ch); end
        applyStimulus(4'b0100, 4'b0100, 4'b0000);
        total++; if (det_hit !== 1'b1 || det_ch !== 2'd2) begin bad++; $display("[TB] FAIL iso_hit: got hit=%0b ch=%0d want 1/2", det_hit, det_ch); end
        total++; if (hit_cnt[31:24] !== 8'd0 || hit_cnt[23:16] !== 8'd1) begin bad++; $display("[TB] FAIL iso_cnt: got %0h", hit_cnt); end
    endtask

    // Wrap from rr_ptr=3, then pointer continuing past ch1.
    task automatic test_wrap();
        logic [3:0] order [4];
        order = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        doReset();
        applyStimulus(4'b0100, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1111, 4'b0000, 4'b0000);
            total++; if (seen_ready !== order[i]) begin bad++; $display("[TB] FAIL wrap_order: got %b want %b", seen_ready, order[i]); end
        end
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        applyStimulus(4'b0011, 4'b0000, 4'b0000);
        total++; if (seen_ready !== 4'b0001) begin bad++; $display("[TB] FAIL wrap_after1: got %b want 0001", seen_ready); end
    endtask

    // clr_ch[2] on the 4th bit of 1,0,1,1; then a clean 1,0,1,1.
    task automatic test_clear();
        logic [3:0] s;
        s = 4'b1011;
        doReset();
        for (int i = 3; i >= 1; i--) applyStimulus(4'b0100, {1'b0, s[i], 2'b00}, 4'b0000);
        applyStimulus(4'b0100, 4'b0100, 4'b0100);
        total++; if (seen_ready !== 4'b0000) begin bad++; $display("[TB] FAIL clr_ready: got %b want 0000", seen_ready); end
        total++; if (det_valid !== 1'b0 || det_hit !== 1'b0) begin bad++; $display("[TB] FAIL clr_det: got dv=%0b hit=%0b want 0/0", det_valid, det_hit); end
        total++; if (hit_cnt[23:16] !== 8'd0) begin bad++; $display("[TB] FAIL clr_cnt: got %0d want 0", hit_cnt[23:16]); end
        for (int i = 3; i >= 0; i--) applyStimulus(4'b0100, {1'b0, s[i], 2'b00}, 4'b0000);
        total++; if (det_hit !== 1'b1 || hit_cnt[23:16] !== 8'd1) begin bad++; $display("[TB] FAIL clr_rehit: got hit=%0b cnt=%0d want 1/1", det_hit, hit_cnt[23:16]); end
    endtask

    // Random traffic on all channels checked against the model each cycle.
    task automatic test_random();
        logic [3:0] v, b, c;
        doReset();
        for (int n = 0; n < 400; n++) begin
            v = 4'($urandom);
            b = 4'($urandom);
            c = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            applyStimulus(v, b, c);
            total++; if (seen_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready: got %b want %b", seen_ready, exp_ready); end
            total++; if (det_valid !== exp_dv || det_hit !== exp_dh || det_ch !== exp_dch) begin bad++; $display("[TB] FAIL rnd_det: got %0b/%0b/%0d want %0b/%0b/%0d", det_valid, det_hit, det_ch, exp_dv, exp_dh, exp_dch); end
            for (int i = 0; i < 4; i++) begin
                total++; if (hit_cnt[i*8 +: 8] !== 8'(exp_cnt[i])) begin bad++; $display("[TB] FAIL rnd_cnt%0d: got %0d want %0d", i, hit_cnt[i*8 +: 8], exp_cnt[i]); end
            end
        end
    endtask

    // CNT_W=2 saturation and mid-stream reset.
    task automatic test_saturate();
        logic [12:0] seq;
        int hits;
        int tab [4];
        seq = 13'b1011011011011; hits = 0; tab = '{1, 2, 3, 3};
        applyStimulus2(1'b0, 1'b0, 1'b1);
        applyStimulus2(1'b0, 1'b0, 1'b1);
        for (int i = 12; i >= 0; i--) begin
            applyStimulus2(1'b1, seq[i], 1'b0);
            total++; if (det_hit2 !== exp_dh2) begin bad++; $display("[TB] FAIL sat_hit: got %0b want %0b", det_hit2, exp_dh2); end
            if (exp_dh2 && hits < 4) begin
                total++; if (hit_cnt2[1:0] !== 2'(tab[hits])) begin bad++; $display("[TB] FAIL sat_cnt: got %0d want %0d", hit_cnt2[1:0], tab[hits]); end
                hits++;
            end
        end
        total++; if (hits != 4) begin bad++; $display("[TB] FAIL sat_hits: got %0d want 4", hits); end
        applyStimulus2(1'b1, 1'b1, 1'b0);
        applyStimulus2(1'b1, 1'b0, 1'b0);
        applyStimulus2(1'b1, 1'b1, 1'b0);
        applyStimulus2(1'b1, 1'b1, 1'b1);
        total++; if (det_valid2 !== 1'b0 || det_hit2 !== 1'b0 || det_ch2 !== 2'd0 || hit_cnt2 !== 8'd0) begin bad++; $display("[TB] FAIL rst_mid: got dv=%0b hit=%0b ch=%0d cnt=%0h want all 0", det_valid2, det_hit2, det_ch2, hit_cnt2); end
        applyStimulus2(1'b1, 1'b1, 1'b0);
        total++; if (det_valid2 !== 1'b1 || det_hit2 !== 1'b0) begin bad++; $display("[TB] FAIL rst_next: got dv=%0b hit=%0b want 1/0", det_valid2, det_hit2); end
        applyStimulus2(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset2 = 1'b1; ch_valid2 = '0; ch_bit2 = '0; clr_ch2 = '0;
        mhist2 = '0; exp_cnt2 = 0; exp_dh2 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_isolation();
        test_wrap();
        test_clear();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
